// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//
// Fetches instruction words sequentially ahead of the IF stage and buffers
// up to DEPTH {instr, pc} pairs in a circular queue. The head entry goes to
// IF through a valid/ready handshake. A taken branch or jump (redirect)
// flushes the queue and restarts fetch from the new target. A memory
// response that is still in flight at that point is waited out and dropped.
//
// Parameters:
//   DEPTH     queue entries; a power of two from 2 to 16
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   redirect     taken branch or jump; flush the queue and refetch
//   redirect_pc  new fetch address; the low two bits are ignored
//   mem_req      fetch request; held until mem_ack
//   mem_addr     word-aligned byte address of the request
//   mem_ack      response valid; completes the request
//   mem_rdata    instruction word returned with mem_ack
//   instr_valid  head entry available
//   instr        head instruction; 32'h0 when instr_valid is low
//   instr_pc     PC of the head instruction
//   instr_ready  IF consumes the head entry this cycle
//   align_err    sticky flag for a misaligned redirect target
//
// Optional feature:
//   PREFETCH_ALIGN_CHK_EN  when defined, a redirect whose target has
//                          nonzero bits [1:0] sets align_err. The flag
//                          stays set until reset. When the macro is
//                          undefined, align_err is tied low.

module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        align_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   target_pc;
  logic [31:0]   target_pc_next;
  logic [31:0]   redirect_aligned;

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_next;

  logic          push;
  logic          pop;
  logic          can_issue;

  assign redirect_aligned = redirect_pc & ~32'h3;

  // A redirect overrides everything else: no pop is taken and no acked
  // data is kept in the cycle it arrives.
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign push        = (state == WAIT) && mem_ack && !redirect;

  // A request goes out only when the slot for its response is already free
  // in next cycle's occupancy. An ack can therefore never meet a full queue.
  assign occ_next  = redirect ? '0 : (count + CW'(push) - CW'(pop));
  assign can_issue = (occ_next < CW'(DEPTH));

  // fetch_pc is the address on the bus. It stays frozen while a request is
  // unacknowledged. A redirect that arrives during that time is parked in
  // target_pc.
  assign mem_req  = (state != IDLE);
  assign mem_addr = fetch_pc;

  assign instr    = instr_valid ? q_instr[rd_ptr] : 32'h0;
  assign instr_pc = instr_valid ? q_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      target_pc <= RESET_PC;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      target_pc <= target_pc_next;
    end
  end

  always_comb begin
    state_next     = state;
    fetch_pc_next  = fetch_pc;
    target_pc_next = target_pc;
    case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
          state_next    = WAIT;
        end else if (can_issue) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          if (redirect) begin
            fetch_pc_next = redirect_aligned;
            state_next    = WAIT;
          end else begin
            fetch_pc_next = fetch_pc + 32'd4;
            state_next    = can_issue ? WAIT : IDLE;
          end
        end else if (redirect) begin
          target_pc_next = redirect_aligned;
          state_next     = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect) begin
          target_pc_next = redirect_aligned;
        end
        if (mem_ack) begin
          fetch_pc_next = redirect ? redirect_aligned : target_pc;
          state_next    = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The storage needs no reset. The head is only shown once count marks
  // it as written.
  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= fetch_pc;
    end
  end

`ifdef PREFETCH_ALIGN_CHK_EN
  logic align_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      align_err_q <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      align_err_q <= 1'b1;
    end
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

endmodule
